uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, number of byte entries in the transmit FIFO; power of two, 2..16.
REQ-003 clk  input  1  single system clock; every flop is clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low: rst=0 resets the block.
REQ-005 data  input  8  byte to transmit; sampled when the byte is accepted.
REQ-006 we  input  1  write strobe; one byte is offered per cycle in which we=1.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH bytes; writes are not accepted while full=1.
REQ-008 ovf  output  1  one-cycle pulse when we=1 while full=1; that byte is dropped.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 uart  output  1  serial line; idle level is 1.

Function
REQ-011 Frame format: 8N1, sent as 1 start bit (0), data[0]..data[7] (LSB first), then 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-012 Write acceptance: a byte is accepted in a cycle with we=1 and full=0, and is pushed into the FIFO at that clock edge.
REQ-013 Write and pop in the same cycle while full=1: the pop takes effect, but the write is still rejected and ovf pulses, because full is evaluated before the edge.
REQ-014 FSM states are IDLE, START, DATA and STOP.
REQ-015 IDLE -> START when the FIFO is non-empty; the byte is popped into the shift register on that same edge.
REQ-016 START -> DATA after CLKS_PER_BIT cycles.
REQ-017 DATA: the shift register shifts right once per bit period; after 8 bits it goes to STOP.
REQ-018 STOP -> START directly if the FIFO is non-empty at the end of the stop bit, otherwise STOP -> IDLE; back-to-back frames have no idle gap.
REQ-019 Latency: with the FIFO empty and the FSM in IDLE, a write in cycle N gives the uart falling edge (start bit) registered at the edge ending cycle N+2.
REQ-020 uart is driven directly from a flop and is glitch-free.
REQ-021 Bit-period counter: 16-bit down-counter; it reloads CLKS_PER_BIT-1 at each bit start, and a tick is asserted when it reaches 0.
REQ-022 Bit counter: 3-bit; it wraps 7->0 on the DATA->STOP transition.
REQ-023 FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; full and empty are decoded from the extra MSB; pointers wrap modulo 2*FIFO_DEPTH.
REQ-024 busy = (state != IDLE) | ~empty.
REQ-025 A frame in progress is never aborted or altered by FIFO activity.

Reset
REQ-026 While rst=0: uart=1, state=IDLE, FIFO empty, full=0, ovf=0, busy=0, all counters 0.
REQ-027 Reset asserted mid-frame: the frame is abandoned immediately, uart returns to 1 asynchronously, and FIFO contents are discarded.
REQ-028 Reset deassertion is synchronized externally; the first write is honoured in the first cycle after rst=1.

Structure
REQ-029 Package uart_pkg holds the default CLKS_PER_BIT, the frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1) and the typedef enum tx_state_t {IDLE, START, DATA, STOP}.
REQ-030 The bit-period counter is a sub-module, uart_baud_tick (inputs clk, rst, restart; output tick), reusable by the receive path.
REQ-031 The FIFO is inline register-array storage, not a separate module.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Single write of 0x55 from idle -> uart line reads 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; frame is 40 cycles; busy falls after the stop bit.
REQ-033 Four back-to-back writes of 0x01, 0x80, 0xFF, 0x00 -> four contiguous frames (160 cycles) with no idle gap; bytes appear in order.
REQ-034 Six writes in six consecutive cycles -> full=1 when the FIFO holds 4 bytes; one ovf pulse; exactly the 5 accepted bytes are transmitted (1 in flight, 4 queued).
REQ-035 rst pulled to 0 during data bit 3 of 0xA5 -> uart=1 within the same cycle; full=0, busy=0; the next write of 0x3C is transmitted as a clean frame.
REQ-036 Loopback to the existing receiver with CLKS_PER_BIT matched, 256 random bytes -> every byte is received intact and in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, 8N1 frame constants, TX FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // 50 MHz system clock / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-write side of the UART transmitter plus its status and serial line.
// Latency: n/a (wires only).
// Backpressure: writer must hold off while full=1; a write against full is dropped and flagged by ovf.
interface uart_tx_if;

    logic [uart_pkg::DATA_BITS-1:0] data;
    logic                           we;
    logic                           full;
    logic                           ovf;
    logic                           busy;
    logic                           uart;

    modport master (
        output data,
        output we,
        input  full,
        input  ovf,
        input  busy,
        input  uart
    );

    modport slave (
        input  data,
        input  we,
        output full,
        output ovf,
        output busy,
        output uart
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: 16-bit down-counter, tick while it sits at zero.
// Latency: first tick CLKS_PER_BIT-1 cycles after the cycle following restart; then every CLKS_PER_BIT cycles.
// Backpressure: none; free-running, restart realigns it to a bit boundary.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    // Reload at each bit start (explicit restart or end of the previous period), otherwise count down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || (cnt == 16'd0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    assign tick = (cnt == 16'd0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift register.
// Latency: byte written in cycle N (FIFO empty, idle) shows its start bit on the line from the edge ending cycle N+2.
// Backpressure: full=1 when FIFO_DEPTH bytes are queued; writes during full are dropped with a one-cycle ovf.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // FIFO storage and pointers; the extra pointer MSB tells full from empty.
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_cnt;
    logic                 uart_q;
    logic                 tick;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // full is judged on pre-edge state, so a write racing a pop against a full FIFO still loses.
    assign push = bus.we && !full;

    // The FIFO is only drained when a new frame begins: from idle, or straight out of a finished stop bit.
    assign pop  = !empty && ((state == IDLE) || ((state == STOP) && tick));

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (pop),
        .tick    (tick)
    );

    // Byte storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.data;
        end
    end

    // FIFO pointers, wrapping modulo 2*FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Frame sequencer; the line flop follows the state one cycle behind so every bit keeps its full width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            uart_q  <= STOP_BIT;
        end else begin
            unique case (state)
                START:   uart_q <= START_BIT;
                DATA:    uart_q <= shreg[0];
                default: uart_q <= STOP_BIT;
            endcase

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shreg <= mem[rd_ptr[AW-1:0]];
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (pop) begin
                            shreg <= mem[rd_ptr[AW-1:0]];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full = full;
    assign bus.ovf  = bus.we && full;
    assign bus.busy = (state != IDLE) || !empty;
    assign bus.uart = uart_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line monitor decodes frames independently of the DUT into a byte queue.
// Inputs change after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         rx_bad = 0;

    always @(posedge clk) cyc++;

    // Line decoder: hunts for a low level, samples each bit in its middle, checks the stop bit.
    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh  = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            mon_act = 1'b0;
            mon_cnt = 0;
        end else begin
            if (!mon_act && (bus.uart === 1'b0)) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                rx_t.push_back(cyc);
            end
            if (mon_act) begin
                if ((mon_cnt == CPB / 2) && (bus.uart !== 1'b0)) rx_bad++;
                if ((mon_cnt > CPB) && (mon_cnt < 9 * CPB) && ((mon_cnt % CPB) == CPB / 2))
                    mon_sh = {bus.uart, mon_sh[7:1]};
                if (mon_cnt == 9 * CPB + CPB / 2) begin
                    if (bus.uart !== 1'b1) rx_bad++;
                    rx_q.push_back(mon_sh);
                end
                if (mon_cnt == FRAME - 1) mon_act = 1'b0;
                else mon_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while ((rx_q.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_timeout"}, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic get_rx(input logic [7:0] exp, input string tag);
        logic [31:0] got;
        got = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hDEAD;
        chk(tag, got, 32'(exp));
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(posedge clk);
        #1 bus.we = 1'b1;
        bus.data = b;
        @(posedge clk);
        #1 bus.we = 1'b0;
    endtask

    logic [7:0] v4 [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
    logic [7:0] v6 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
    logic [7:0] exp_q [$];

    initial begin
        logic [9:0] f;
        int         gap;
        int         sent;
        int         guard;
        logic [7:0] b;

        bus.we   = 1'b0;
        bus.data = 8'h00;

        // Reset state, including a write attempt while held in reset
        repeat (3) @(negedge clk);
        bus.we   = 1'b1;
        bus.data = 8'hEE;
        @(negedge clk);
        chk("rst_uart", 32'(bus.uart), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_ovf",  32'(bus.ovf),  32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        bus.we = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_uart", 32'(bus.uart), 32'd1);

        // Single 0x55 from idle: latency, exact per-cycle line levels, busy release
        write_byte(8'h55);
        @(negedge clk);
        chk("lat_c1_uart", 32'(bus.uart), 32'd1);
        @(negedge clk);
        chk("lat_c2_uart", 32'(bus.uart), 32'd1);
        chk("lat_c2_busy", 32'(bus.busy), 32'd1);
        f = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            chk($sformatf("f55_c%0d", k), 32'(bus.uart), 32'(f[k / CPB]));
        end
        @(negedge clk);
        chk("f55_busy_end", 32'(bus.busy), 32'd0);
        chk("f55_uart_end", 32'(bus.uart), 32'd1);
        wait_rx(1, 10, "f55");
        get_rx(8'h55, "f55_byte");
        rx_q.delete();
        rx_t.delete();

        // Four back-to-back writes: contiguous frames in order
        @(posedge clk);
        #1 bus.we = 1'b1;
        bus.data = v4[0];
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1 bus.data = v4[i];
        end
        @(posedge clk);
        #1 bus.we = 1'b0;
        wait_rx(4, 4 * FRAME + 20, "b2b");
        for (int i = 1; i < 4; i++) begin
            gap = (rx_t.size() > i) ? (rx_t[i] - rx_t[i-1]) : -1;
            chk($sformatf("b2b_gap%0d", i), 32'(gap), 32'(FRAME));
        end
        for (int i = 0; i < 4; i++) get_rx(v4[i], $sformatf("b2b_byte%0d", i));
        repeat (4) @(negedge clk);
        chk("b2b_busy_end", 32'(bus.busy), 32'd0);
        rx_q.delete();
        rx_t.delete();

        // Six writes in six cycles: fill, one overflow, five bytes out
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 bus.we = 1'b1;
            bus.data = v6[i];
            @(negedge clk);
            chk($sformatf("ovf_full_w%0d", i), 32'(bus.full), 32'(i == 5));
            chk($sformatf("ovf_pulse_w%0d", i), 32'(bus.ovf), 32'(i == 5));
        end
        @(posedge clk);
        #1 bus.we = 1'b0;
        @(negedge clk);
        chk("ovf_full_hold", 32'(bus.full), 32'd1);
        chk("ovf_single",    32'(bus.ovf),  32'd0);
        wait_rx(5, 5 * FRAME + 20, "ovf");
        for (int i = 0; i < 5; i++) get_rx(v6[i], $sformatf("ovf_byte%0d", i));
        repeat (FRAME) @(negedge clk);
        chk("ovf_no_sixth", 32'(rx_q.size()), 32'd0);
        chk("ovf_busy_end", 32'(bus.busy), 32'd0);
        rx_q.delete();
        rx_t.delete();

        // Reset during data bit 3 of 0xA5 with 0x5A still queued, then a clean 0x3C
        @(posedge clk);
        #1 bus.we = 1'b1;
        bus.data = 8'hA5;
        @(posedge clk);
        #1 bus.data = 8'h5A;
        @(posedge clk);
        #1 bus.we = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        chk("mid_pre_uart", 32'(bus.uart), 32'd0);
        chk("mid_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_uart", 32'(bus.uart), 32'd1);
        chk("mid_rst_full", 32'(bus.full), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_hold_uart", 32'(bus.uart), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.we   = 1'b1;
        bus.data = 8'h3C;
        @(posedge clk);
        #1 bus.we = 1'b0;
        wait_rx(1, FRAME + 20, "mid");
        get_rx(8'h3C, "mid_byte");
        repeat (FRAME) @(negedge clk);
        chk("mid_no_stale", 32'(rx_q.size()), 32'd0);
        chk("mid_busy_end", 32'(bus.busy), 32'd0);
        rx_q.delete();
        rx_t.delete();

        // Random bytes written only while not full
        sent  = 0;
        guard = 0;
        while ((sent < 12) && (guard < 2000)) begin
            @(negedge clk);
            guard++;
            if (!bus.full) begin
                b        = 8'($urandom);
                bus.we   = 1'b1;
                bus.data = b;
                exp_q.push_back(b);
                sent++;
            end else begin
                bus.we = 1'b0;
            end
        end
        @(negedge clk);
        bus.we = 1'b0;
        chk("rnd_sent", 32'(sent), 32'd12);
        wait_rx(12, 12 * FRAME + 50, "rnd");
        for (int i = 0; i < 12; i++) begin
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            get_rx(b, $sformatf("rnd_byte%0d", i));
        end
        chk("framing_errs", 32'(rx_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
